// File: rtl/oflow_MEM_buffer_pkg.sv
// Shared types and sizing for the MEM history buffer frame scheduler.
package oflow_MEM_buffer_pkg;

    localparam int unsigned NUM_SLOTS                   = 5;
    localparam int unsigned ADDR_WIDTH                  = 6;
    localparam int unsigned MAX_BBOX                    = 32;
    localparam int unsigned SLOT_WIDTH                  = 3;
    localparam int unsigned TOTAL_FRAME_NUM_WIDTH       = 8;
    localparam int unsigned NUM_OF_HISTORY_FRAMES_WIDTH = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_COMMIT,
        ST_READ_START,
        ST_READ_WAIT,
        ST_DONE
    } sched_state_e;

    // Circular successor of a slot index.
    function automatic logic [SLOT_WIDTH-1:0] next_slot(input logic [SLOT_WIDTH-1:0] slot);
        return (slot == SLOT_WIDTH'(NUM_SLOTS - 1)) ? '0 : slot + SLOT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/oflow_slot_ptr.sv
// Wrap-around frame slot pointer and saturating count of retired history frames.
module oflow_slot_ptr
    import oflow_MEM_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  advance,
    output logic [SLOT_WIDTH-1:0] slot_ptr,
    output logic [SLOT_WIDTH-1:0] history_avail
);

    logic [SLOT_WIDTH-1:0] slot_q,  slot_d;
    logic [SLOT_WIDTH-1:0] avail_q, avail_d;

    always_comb begin
        slot_d  = slot_q;
        avail_d = avail_q;
        if (advance) begin
            slot_d = next_slot(slot_q);
            if (avail_q != SLOT_WIDTH'(NUM_SLOTS - 1)) begin
                avail_d = avail_q + SLOT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q  <= '0;
            avail_q <= '0;
        end else begin
            slot_q  <= slot_d;
            avail_q <= avail_d;
        end
    end

    assign slot_ptr      = slot_q;
    assign history_avail = avail_q;

endmodule

// File: rtl/oflow_buffer_frame_sched.sv
// Per-frame scheduler: write bboxes into a circular slot, commit its end pointer,
// launch the history read and retire the frame. Write and read never overlap.
module oflow_buffer_frame_sched
    import oflow_MEM_buffer_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   reset_N,
    input  logic                                   start_frame,
    input  logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_num,
    input  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames,
    input  logic                                   empty_frame,
    input  logic                                   bbox_valid,
    input  logic                                   bbox_last,
    output logic                                   bbox_ready,
    output logic                                   we,
    output logic [SLOT_WIDTH-1:0]                  write_slot,
    output logic [ADDR_WIDTH-1:0]                  write_addr,
    output logic [NUM_SLOTS-1:0][ADDR_WIDTH-1:0]   end_pointers,
    output logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_to_process,
    output logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] valid_history_frames,
    output logic                                   start_read,
    input  logic                                   done_read,
    output logic                                   frame_done,
    output logic                                   busy,
    output logic                                   bbox_overflow
);

    sched_state_e                               state_q, state_d;
    logic [ADDR_WIDTH-1:0]                      cnt_q, cnt_d;
    logic                                       ovf_q, ovf_d;
    logic [TOTAL_FRAME_NUM_WIDTH-1:0]           frame_q, frame_d;
    logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0]     hist_req_q, hist_req_d;
    logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0]     vhf_q, vhf_d;
    logic [NUM_SLOTS-1:0][ADDR_WIDTH-1:0]       ep_q, ep_d;
    logic                                       start_read_q, start_read_d;
    logic                                       frame_done_q, frame_done_d;
    logic                                       busy_q, busy_d;
    logic                                       ready_q, ready_d;

    logic [SLOT_WIDTH-1:0]                      slot_ptr;
    logic [SLOT_WIDTH-1:0]                      history_avail;
    logic                                       advance_c;
    logic                                       accept_c;
    logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0]     hist_min_c;

    oflow_slot_ptr u_slot_ptr (
        .clk           (clk),
        .rst_n         (reset_N),
        .advance       (advance_c),
        .slot_ptr      (slot_ptr),
        .history_avail (history_avail)
    );

    assign advance_c = (state_q == ST_DONE);
    assign accept_c  = ready_q & bbox_valid;

    // History depth granted to the read: request clamped by what has been retired.
    always_comb begin
        hist_min_c = hist_req_q;
        if (NUM_OF_HISTORY_FRAMES_WIDTH'(history_avail) < hist_min_c) begin
            hist_min_c = NUM_OF_HISTORY_FRAMES_WIDTH'(history_avail);
        end
        if (hist_min_c > NUM_OF_HISTORY_FRAMES_WIDTH'(NUM_SLOTS - 1)) begin
            hist_min_c = NUM_OF_HISTORY_FRAMES_WIDTH'(NUM_SLOTS - 1);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        frame_d    = frame_q;
        hist_req_d = hist_req_q;
        vhf_d      = vhf_q;
        ep_d       = ep_q;

        case (state_q)
            ST_IDLE: begin
                if (start_frame) begin
                    frame_d    = frame_num;
                    hist_req_d = num_of_history_frames;
                    cnt_d      = '0;
                    ovf_d      = 1'b0;
                    state_d    = empty_frame ? ST_COMMIT : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (accept_c) begin
                    if (cnt_q < ADDR_WIDTH'(MAX_BBOX)) begin
                        cnt_d = cnt_q + ADDR_WIDTH'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (bbox_last) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                    if (slot_ptr == SLOT_WIDTH'(i)) begin
                        ep_d[i] = cnt_q;
                    end
                end
                vhf_d   = hist_min_c;
                state_d = (hist_min_c != '0) ? ST_READ_START : ST_DONE;
            end
            ST_READ_START: state_d = ST_READ_WAIT;
            ST_READ_WAIT: begin
                if (done_read) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Status outputs are registered decodes of the upcoming state.
        start_read_d = (state_d == ST_READ_START);
        frame_done_d = (state_d == ST_DONE);
        busy_d       = (state_d != ST_IDLE);
        ready_d      = (state_d == ST_WRITE);
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            frame_q      <= '0;
            hist_req_q   <= '0;
            vhf_q        <= '0;
            ep_q         <= '0;
            start_read_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            frame_q      <= frame_d;
            hist_req_q   <= hist_req_d;
            vhf_q        <= vhf_d;
            ep_q         <= ep_d;
            start_read_q <= start_read_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
        end
    end

    assign bbox_ready           = ready_q;
    assign we                   = accept_c & (cnt_q < ADDR_WIDTH'(MAX_BBOX));
    assign write_addr           = cnt_q;
    assign write_slot           = slot_ptr;
    assign end_pointers         = ep_q;
    assign frame_to_process     = frame_q;
    assign valid_history_frames = vhf_q;
    assign start_read           = start_read_q;
    assign frame_done           = frame_done_q;
    assign busy                 = busy_q;
    assign bbox_overflow        = ovf_q;

endmodule

// File: tb/tb_oflow_buffer_frame_sched.sv
// Bench for the frame scheduler: hand-computed frame table, corner sequences and
// random frames checked against a frame-level reference model.
module tb_oflow_buffer_frame_sched;

    localparam int NSLOT = 5;
    localparam int MAXB  = 32;
    localparam int MAXH  = NSLOT - 1;

    logic             clk = 1'b0;
    logic             reset_N;
    logic             start_frame;
    logic [7:0]       frame_num;
    logic [2:0]       num_of_history_frames;
    logic             empty_frame;
    logic             bbox_valid;
    logic             bbox_last;
    logic             bbox_ready;
    logic             we;
    logic [2:0]       write_slot;
    logic [5:0]       write_addr;
    logic [4:0][5:0]  end_pointers;
    logic [7:0]       frame_to_process;
    logic [2:0]       valid_history_frames;
    logic             start_read;
    logic             done_read;
    logic             frame_done;
    logic             busy;
    logic             bbox_overflow;

    oflow_buffer_frame_sched dut (
        .clk                   (clk),
        .reset_N               (reset_N),
        .start_frame           (start_frame),
        .frame_num             (frame_num),
        .num_of_history_frames (num_of_history_frames),
        .empty_frame           (empty_frame),
        .bbox_valid            (bbox_valid),
        .bbox_last             (bbox_last),
        .bbox_ready            (bbox_ready),
        .we                    (we),
        .write_slot            (write_slot),
        .write_addr            (write_addr),
        .end_pointers          (end_pointers),
        .frame_to_process      (frame_to_process),
        .valid_history_frames  (valid_history_frames),
        .start_read            (start_read),
        .done_read             (done_read),
        .frame_done            (frame_done),
        .busy                  (busy),
        .bbox_overflow         (bbox_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] fnum;
        logic [2:0] nhist;
        logic       empty;
        int         nbbox;
        int         rd;
        logic       poke;
        logic [2:0] e_slot;
        logic [2:0] e_vhf;
        logic [5:0] e_ep;
        logic       e_ovf;
    } vec_t;

    vec_t       tbl [8];
    int         n_vec  = 0;
    int         n_fail = 0;
    logic       last_ovf = 1'b0;

    // Reference model: frames retired since reset and committed bbox count per slot.
    int         retired = 0;
    int         mdl_ep [NSLOT];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        retired  = 0;
        last_ovf = 1'b0;
        for (int s = 0; s < NSLOT; s++) mdl_ep[s] = 0;
    endtask

    task automatic model_expect(input logic [2:0] nhist, input logic empty, input int nbbox,
                                output logic [2:0] slot, output logic [2:0] vhf,
                                output logic [5:0] ep, output logic ovf);
        int h;
        h = nhist;
        if (retired < h) h = retired;
        if (MAXH < h) h = MAXH;
        slot = 3'(retired % NSLOT);
        vhf  = 3'(h);
        ep   = empty ? 6'd0 : 6'((nbbox > MAXB) ? MAXB : nbbox);
        ovf  = !empty && (nbbox > MAXB);
    endtask

    task automatic model_retire(input logic [2:0] slot, input logic [5:0] ep);
        mdl_ep[slot] = ep;
        retired++;
        for (int s = 0; s < NSLOT; s++) chk("end_ptr_all", end_pointers[s], mdl_ep[s]);
    endtask

    // Drives one whole frame and checks cycle-accurate behaviour. Called at posedge+1.
    task automatic run_frame(input logic [7:0] fnum, input logic [2:0] nhist, input logic empty,
                             input int nbbox, input int rd, input logic poke, input logic gaps,
                             input logic [2:0] e_slot, input logic [2:0] e_vhf,
                             input logic [5:0] e_ep, input logic e_ovf);
        chk("idle_busy", busy, 0);
        chk("idle_ovf_sticky", bbox_overflow, last_ovf);
        chk("idle_ready", bbox_ready, 0);
        start_frame = 1'b1; frame_num = fnum; num_of_history_frames = nhist; empty_frame = empty;
        tick();
        start_frame = 1'b0; empty_frame = 1'b0;
        frame_num = 8'($urandom); num_of_history_frames = 3'($urandom);
        chk("start_busy", busy, 1);
        chk("frame_latch", frame_to_process, fnum);
        chk("ovf_cleared", bbox_overflow, 0);
        if (!empty) begin
            for (int i = 0; i < nbbox; i++) begin
                if (gaps && $urandom_range(0, 3) == 0) begin
                    bbox_valid = 1'b0; bbox_last = 1'($urandom);
                    #1;
                    chk("gap_we", we, 0);
                    chk("gap_ready", bbox_ready, 1);
                    tick();
                    bbox_last = 1'b0;
                end
                chk("ready", bbox_ready, 1);
                chk("ovf_run", bbox_overflow, i > MAXB);
                bbox_valid = 1'b1; bbox_last = (i == nbbox - 1);
                #1;
                chk("we", we, i < MAXB);
                if (i < MAXB) begin
                    chk("waddr", write_addr, i);
                    chk("wslot", write_slot, e_slot);
                end
                tick();
                bbox_valid = 1'b0; bbox_last = 1'b0;
            end
        end
        chk("commit_ready", bbox_ready, 0);
        chk("commit_ovf", bbox_overflow, e_ovf);
        chk("commit_sr", start_read, 0);
        tick();
        chk("end_ptr", end_pointers[e_slot], e_ep);
        chk("vhf", valid_history_frames, e_vhf);
        if (e_vhf != 3'd0) begin
            chk("start_read", start_read, 1);
            chk("rs_fd", frame_done, 0);
            if (poke) begin
                done_read = 1'b1; start_frame = 1'b1;
            end
            tick();
            done_read = 1'b0;
            chk("start_read_1cyc", start_read, 0);
            chk("wait_busy", busy, 1);
            for (int k = 0; k < rd; k++) begin
                chk("wait_fd", frame_done, 0);
                chk("wait_sr", start_read, 0);
                chk("wait_ready", bbox_ready, 0);
                tick();
                start_frame = 1'b0;
            end
            start_frame = 1'b0;
            done_read = 1'b1;
            tick();
            done_read = 1'b0;
        end else begin
            chk("no_start_read", start_read, 0);
        end
        chk("frame_done", frame_done, 1);
        chk("done_busy", busy, 1);
        tick();
        chk("fd_1cyc", frame_done, 0);
        chk("back_idle", busy, 0);
        last_ovf = e_ovf;
        model_retire(e_slot, e_ep);
    endtask

    initial begin
        logic [2:0] m_slot, m_vhf;
        logic [5:0] m_ep;
        logic       m_ovf;
        logic [2:0] nh;
        logic       em;
        int         nb;

        tbl[0] = '{8'd12, 3'd3, 1'b0,  9,  0, 1'b0, 3'd0, 3'd0, 6'd9,  1'b0};
        tbl[1] = '{8'd13, 3'd3, 1'b0,  5,  2, 1'b0, 3'd1, 3'd1, 6'd5,  1'b0};
        tbl[2] = '{8'd14, 3'd5, 1'b0,  3, 10, 1'b0, 3'd2, 3'd2, 6'd3,  1'b0};
        tbl[3] = '{8'd15, 3'd7, 1'b0, 35,  1, 1'b0, 3'd3, 3'd3, 6'd32, 1'b1};
        tbl[4] = '{8'd16, 3'd7, 1'b1,  0,  3, 1'b1, 3'd4, 3'd4, 6'd0,  1'b0};
        tbl[5] = '{8'd17, 3'd6, 1'b0,  2,  0, 1'b0, 3'd0, 3'd4, 6'd2,  1'b0};
        tbl[6] = '{8'd18, 3'd4, 1'b0,  1,  4, 1'b1, 3'd1, 3'd4, 6'd1,  1'b0};
        tbl[7] = '{8'd19, 3'd1, 1'b0, 32,  2, 1'b0, 3'd2, 3'd1, 6'd32, 1'b0};

        reset_N = 1'b0; start_frame = 1'b0; frame_num = '0; num_of_history_frames = '0;
        empty_frame = 1'b0; bbox_valid = 1'b0; bbox_last = 1'b0; done_read = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", bbox_ready, 0);
        chk("rst_ep", end_pointers, 0);
        chk("rst_vhf", valid_history_frames, 0);
        chk("rst_frame", frame_to_process, 0);
        chk("rst_ovf", bbox_overflow, 0);
        @(negedge clk);
        reset_N = 1'b1;
        tick();

        for (int t = 0; t < 8; t++) begin
            run_frame(tbl[t].fnum, tbl[t].nhist, tbl[t].empty, tbl[t].nbbox, tbl[t].rd,
                      tbl[t].poke, 1'b0, tbl[t].e_slot, tbl[t].e_vhf, tbl[t].e_ep, tbl[t].e_ovf);
        end

        // Reset in the middle of a frame's bbox stream.
        start_frame = 1'b1; frame_num = 8'd77; num_of_history_frames = 3'd4; empty_frame = 1'b0;
        tick();
        start_frame = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bbox_valid = 1'b1;
            tick();
        end
        bbox_valid = 1'b0;
        chk("pre_rst_ready", bbox_ready, 1);
        #2;
        reset_N = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", bbox_ready, 0);
        chk("mid_rst_we", we, 0);
        chk("mid_rst_ep", end_pointers, 0);
        chk("mid_rst_vhf", valid_history_frames, 0);
        chk("mid_rst_frame", frame_to_process, 0);
        chk("mid_rst_slot", write_slot, 0);
        chk("mid_rst_addr", write_addr, 0);
        chk("mid_rst_fd", frame_done, 0);
        model_reset();
        @(negedge clk);
        reset_N = 1'b1;
        tick();
        chk("post_rst_fd", frame_done, 0);
        model_expect(3'd2, 1'b0, 6, m_slot, m_vhf, m_ep, m_ovf);
        run_frame(8'd78, 3'd2, 1'b0, 6, 0, 1'b0, 1'b0, m_slot, m_vhf, m_ep, m_ovf);

        // Random frames against the reference model.
        for (int r = 0; r < 24; r++) begin
            nh = 3'($urandom_range(0, 7));
            em = ($urandom_range(0, 7) == 0);
            nb = $urandom_range(1, 40);
            model_expect(nh, em, nb, m_slot, m_vhf, m_ep, m_ovf);
            run_frame(8'($urandom), nh, em, nb, $urandom_range(0, 6), 1'($urandom), 1'b1,
                      m_slot, m_vhf, m_ep, m_ovf);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
